// File: rtl/rf_write_ctrl.sv
// rf_write_ctrl: round-robin owner of the register-file write port for requesters A and B.
// Define RF_CLEAR_EN to zero every register after reset before any write is accepted.
module rf_write_ctrl #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         a_valid,
  input  logic [D-1:0] a_addr,
  input  logic [W-1:0] a_data,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [D-1:0] b_addr,
  input  logic [W-1:0] b_data,
  output logic         b_ready,
  output logic         rf_write_en,
  output logic [D-1:0] rf_waddr,
  output logic [W-1:0] rf_data_in,
  output logic         busy,
  output logic         last_grant
);

  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;

  logic         ptr_q, ptr_d;
  logic         last_grant_q, last_grant_d;
  logic         rf_write_en_q, rf_write_en_d;
  logic [D-1:0] rf_waddr_q, rf_waddr_d;
  logic [W-1:0] rf_data_in_q, rf_data_in_d;
  logic         run;
  logic         a_fire, b_fire;

`ifdef RF_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_t;
  state_t       state_q, state_d;
  logic [D-1:0] cnt_q, cnt_d;

  assign run  = (state_q == RUN);
  assign busy = (state_q == CLEAR);
`else
  assign run  = 1'b1;
  assign busy = 1'b0;
`endif

  // Readies never look at their own valid, so a requester cannot loop valid on ready.
  assign a_ready = run && (!b_valid || (ptr_q == PTR_A));
  assign b_ready = run && (!a_valid || (ptr_q == PTR_B));
  assign a_fire  = a_valid && a_ready;
  assign b_fire  = b_valid && b_ready;

  always_comb begin
    ptr_d         = ptr_q;
    last_grant_d  = last_grant_q;
    rf_write_en_d = 1'b0;
    rf_waddr_d    = rf_waddr_q;
    rf_data_in_d  = rf_data_in_q;
`ifdef RF_CLEAR_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      rf_write_en_d = 1'b1;
      rf_waddr_d    = cnt_q;
      rf_data_in_d  = '0;
      cnt_d         = cnt_q + 1'b1;
      if (cnt_q == {D{1'b1}}) begin
        state_d = RUN;
      end
    end
`endif
    // Readies are zero outside RUN, so a fire never collides with a clear write.
    if (a_fire) begin
      rf_write_en_d = 1'b1;
      rf_waddr_d    = a_addr;
      rf_data_in_d  = a_data;
      ptr_d         = PTR_B;
      last_grant_d  = 1'b0;
    end else if (b_fire) begin
      rf_write_en_d = 1'b1;
      rf_waddr_d    = b_addr;
      rf_data_in_d  = b_data;
      ptr_d         = PTR_A;
      last_grant_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      ptr_q         <= PTR_A;
      last_grant_q  <= 1'b0;
      rf_write_en_q <= 1'b0;
      rf_waddr_q    <= '0;
      rf_data_in_q  <= '0;
`ifdef RF_CLEAR_EN
      state_q       <= CLEAR;
      cnt_q         <= '0;
`endif
    end else begin
      ptr_q         <= ptr_d;
      last_grant_q  <= last_grant_d;
      rf_write_en_q <= rf_write_en_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_data_in_q  <= rf_data_in_d;
`ifdef RF_CLEAR_EN
      state_q       <= state_d;
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign rf_write_en = rf_write_en_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_data_in  = rf_data_in_q;
  assign last_grant  = last_grant_q;

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Scoreboard bench for rf_write_ctrl: a transaction-level model predicts each register-file write.
module tb_rf_write_ctrl;
  localparam int W = 8;
  localparam int D = 4;
  localparam int N = 16;
`ifdef RF_CLEAR_EN
  localparam int CLR = N;
`else
  localparam int CLR = 0;
`endif

  logic         CLK = 1'b0;
  logic         Reset = 1'b1;
  logic         a_valid = 1'b0, b_valid = 1'b0;
  logic [D-1:0] a_addr = '0, b_addr = '0;
  logic [W-1:0] a_data = '0, b_data = '0;
  logic         a_ready, b_ready, rf_write_en, busy, last_grant;
  logic [D-1:0] rf_waddr;
  logic [W-1:0] rf_data_in;

  rf_write_ctrl #(.W(W), .D(D)) dut (
    .CLK(CLK), .Reset(Reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rf_write_en(rf_write_en), .rf_waddr(rf_waddr), .rf_data_in(rf_data_in),
    .busy(busy), .last_grant(last_grant)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int           cyc;
    logic [D-1:0] addr;
    logic [W-1:0] data;
    logic         grant;
  } wr_t;

  wr_t          exp_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  bit           in_reset = 1'b1;
  bit           a_took, b_took;
  logic         mptr;
  logic [W-1:0] dut_mem [N];
  logic [W-1:0] model_mem [N];
  bit           model_wr [N];

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Monitor: the register file seen by the DUT, and in-order scoreboard of writes.
  always @(negedge CLK) begin
    wr_t e;
    if (rf_write_en === 1'b1) dut_mem[rf_waddr] = rf_data_in;
    if (!in_reset) begin
      if (rf_write_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(rf_waddr), 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          $display("cycle %0d: write addr=%0d data=%02h grant=%0b", cyc, rf_waddr, rf_data_in, last_grant);
          chk("write_cycle", cyc, e.cyc);
          chk("write_addr", 32'(rf_waddr), 32'(e.addr));
          chk("write_data", 32'(rf_data_in), 32'(e.data));
          chk("last_grant", 32'(last_grant), 32'(e.grant));
        end
      end else begin
        chk("write_en_x", 32'(rf_write_en), 32'd0);
        if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          chk("missing_write", cyc, exp_q[0].cyc);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // One cycle: check readies/busy against the model, record any transfer, move to next cycle.
  task automatic tick();
    logic ea, eb;
    a_took = 1'b0;
    b_took = 1'b0;
    @(negedge CLK);
    ea = (cyc >= CLR) && (!b_valid || mptr == 1'b0);
    eb = (cyc >= CLR) && (!a_valid || mptr == 1'b1);
    chk("a_ready", 32'(a_ready), 32'(ea));
    chk("b_ready", 32'(b_ready), 32'(eb));
    chk("busy", 32'(busy), 32'(cyc < CLR));
    if (a_valid && ea) begin
      exp_q.push_back('{cyc + 1, a_addr, a_data, 1'b0});
      model_mem[a_addr] = a_data;
      model_wr[a_addr]  = 1'b1;
      mptr   = 1'b1;
      a_took = 1'b1;
    end else if (b_valid && eb) begin
      exp_q.push_back('{cyc + 1, b_addr, b_data, 1'b1});
      model_mem[b_addr] = b_data;
      model_wr[b_addr]  = 1'b1;
      mptr   = 1'b0;
      b_took = 1'b1;
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic do_reset(int n);
    in_reset = 1'b1;
    Reset    = 1'b1;
    a_valid  = 1'b0;
    b_valid  = 1'b0;
    @(posedge CLK);
    #1;
    chk("rst_write_en", 32'(rf_write_en), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_data", 32'(rf_data_in), 32'd0);
    chk("rst_last_grant", 32'(last_grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'(CLR > 0));
    repeat (n - 1) begin
      @(posedge CLK);
      #1;
    end
    Reset = 1'b0;
    exp_q.delete();
    mptr     = 1'b0;
    cyc      = 0;
    in_reset = 1'b0;
    for (int i = 0; i < CLR; i++) begin
      exp_q.push_back('{i + 1, D'(i), W'(0), 1'b0});
      model_mem[i] = '0;
      model_wr[i]  = 1'b1;
    end
  endtask

  task automatic rand_inputs(int pa, int pb);
    if (!a_valid || a_took) begin
      a_valid = ($urandom_range(99) < pa);
      a_addr  = D'($urandom);
      a_data  = W'($urandom);
    end
    if (!b_valid || b_took) begin
      b_valid = ($urandom_range(99) < pb);
      b_addr  = D'($urandom);
      b_data  = W'($urandom);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) begin
      if (a_valid || b_valid) begin
        tick();
        if (a_took) a_valid = 1'b0;
        if (b_took) b_valid = 1'b0;
      end
    end
    chk("drain_a", 32'(a_valid), 32'd0);
    chk("drain_b", 32'(b_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) model_wr[i] = 1'b0;
    do_reset(3);

    // Reset interrupted at cycle 7, then a full restart.
    repeat (7) tick();
    do_reset(2);

    // B presents in cycle 0 and waits for the clear (if any) to finish.
    b_valid = 1'b1; b_addr = 4'd9; b_data = 8'h3C;
    for (int i = 0; i < CLR + 2; i++) begin
      if (b_valid) begin
        tick();
        if (b_took) b_valid = 1'b0;
      end
    end
    chk("b_first_done", 32'(b_valid), 32'd0);
    repeat (2) tick();

    // Single A write.
    a_valid = 1'b1; a_addr = 4'd3; a_data = 8'hA5;
    tick();
    chk("a_single_taken", 32'(a_took), 32'd1);
    a_valid = 1'b0;
    repeat (2) tick();

    // Align pointer to A, then both requesters hit the top register in the same cycle.
    if (mptr == 1'b1) begin
      b_valid = 1'b1; b_addr = 4'd0; b_data = 8'h5A;
      tick();
      b_valid = 1'b0;
    end
    a_valid = 1'b1; a_addr = 4'd15; a_data = 8'h11;
    b_valid = 1'b1; b_addr = 4'd15; b_data = 8'h22;
    drain();
    repeat (2) tick();
    chk("acc_reg15", 32'(dut_mem[15]), 32'h22);

    // Both valid continuously: grants must alternate.
    a_valid = 1'b1; a_addr = 4'd1; a_data = 8'h01;
    b_valid = 1'b1; b_addr = 4'd2; b_data = 8'h02;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (a_took) a_data = W'($urandom);
      if (b_took) b_data = W'($urandom);
    end
    drain();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      rand_inputs(60, 55);
      tick();
    end
    drain();
    repeat (3) tick();

    chk("queue_drained", exp_q.size(), 0);
    for (int i = 0; i < N; i++) begin
      if (model_wr[i]) chk("final_reg", {24'(i), dut_mem[i]}, {24'(i), model_mem[i]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
